// File: rtl/multicycle_core.sv
// multicycle_core
//   Multi-cycle processor core for a 16-bit instruction subset. Each
//   instruction runs through a FETCH / DECODE / EXEC / MEM / WB state
//   machine. Instruction and data memories have separate req/ack ports, so
//   any memory latency is tolerated. Halt is sticky. Illegal encodings halt
//   the core and set the illegal flag.
//
// Parameters
//   WIDTH   datapath and register width (>= 16)
//   REGS    number of architectural registers (2..16)
//   ADDR_W  width of pc and of both memory addresses
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   halt, illegal      sticky status flags
//   instret            retired-instruction count (wraps at 2^32)
//   imem_req/addr      fetch request, address = pc
//   imem_rdata/ack     instruction word, valid in the ack cycle
//   dmem_req/we/addr   data request, 1 = store, address = r[rs]
//   dmem_wdata         store data = r[rd]
//   dmem_rdata/ack     load data, valid in the ack cycle
module multicycle_core #(
    parameter int WIDTH  = 16,
    parameter int REGS   = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              halt,
    output logic              illegal,
    output logic [31:0]       instret,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WIDTH-1:0]  dmem_wdata,
    input  logic [WIDTH-1:0]  dmem_rdata,
    input  logic              dmem_ack
);

    localparam int RIDX_W = $clog2(REGS);

    localparam logic [3:0] OP_SYS   = 4'h0;  // sub 0 trap, sub 1 jr
    localparam logic [3:0] OP_NOT   = 4'h1;
    localparam logic [3:0] OP_NEG   = 4'h3;
    localparam logic [3:0] OP_MEM   = 4'h4;  // sub 0 load, sub 1 store
    localparam logic [3:0] OP_LOGIC = 4'h5;  // sub 0 and, 1 or, 2 xor
    localparam logic [3:0] OP_ARITH = 4'h7;  // sub 0 add, 1 sub
    localparam logic [3:0] OP_CI8   = 4'hB;
    localparam logic [3:0] OP_BRZ   = 4'hE;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [WIDTH-1:0]  mdr;
    logic [WIDTH-1:0]  regs [REGS];

    // Instruction fields
    logic [3:0]        op, sub, rs_f, rd_f;
    logic [RIDX_W-1:0] rs_idx, rd_idx;
    logic [WIDTH-1:0]  rs_val, rd_val, imm_w;
    logic [ADDR_W-1:0] imm_a;

    assign op     = ir[15:12];
    assign sub    = ir[11:8];
    assign rs_f   = ir[7:4];
    assign rd_f   = ir[3:0];
    assign rs_idx = ir[4 +: RIDX_W];
    assign rd_idx = ir[0 +: RIDX_W];
    assign rs_val = regs[rs_idx];
    assign rd_val = regs[rd_idx];
    assign imm_w  = WIDTH'($signed(ir[11:4]));
    assign imm_a  = ADDR_W'($signed(ir[11:4]));

    // Decode: classify the instruction in ir and flag illegal encodings.
    // not/neg carry no sub-opcode, so their sub field is ignored.
    logic uses_rs, uses_rd, bad_op, is_trap, is_mem, is_store, dec_illegal;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statements can leave a latch behind.
        uses_rs = 1'b0;
        uses_rd = 1'b0;
        bad_op  = 1'b0;
        is_trap = 1'b0;
        is_mem  = 1'b0;
        case (op)
            OP_SYS: begin
                if (sub == 4'h0)      is_trap = 1'b1;
                else if (sub == 4'h1) uses_rd = 1'b1;
                else                  bad_op  = 1'b1;
            end
            OP_NOT, OP_NEG: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
            end
            OP_MEM: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                is_mem  = 1'b1;
                bad_op  = (sub > 4'h1);
            end
            OP_LOGIC: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                bad_op  = (sub > 4'h2);
            end
            OP_ARITH: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                bad_op  = (sub > 4'h1);
            end
            OP_CI8, OP_BRZ: uses_rd = 1'b1;
            default:        bad_op  = 1'b1;
        endcase
        dec_illegal = bad_op
                    || (uses_rs && int'(rs_f) >= REGS)
                    || (uses_rd && int'(rd_f) >= REGS);
    end

    assign is_store = (sub == 4'h1);

    // Execute: register result or control-flow target for the EXEC state.
    // brz adds to the pc that FETCH has already incremented.
    logic              alu_we;
    logic [WIDTH-1:0]  alu_res;
    logic              br_take;
    logic [ADDR_W-1:0] br_target;

    always_comb begin
        alu_we    = 1'b0;
        alu_res   = '0;
        br_take   = 1'b0;
        br_target = pc;
        case (op)
            OP_SYS: begin
                br_take   = 1'b1;
                br_target = ADDR_W'(rd_val);
            end
            OP_NOT: begin
                alu_we  = 1'b1;
                alu_res = ~rs_val;
            end
            OP_NEG: begin
                alu_we  = 1'b1;
                alu_res = -rs_val;
            end
            OP_LOGIC: begin
                alu_we = 1'b1;
                case (sub)
                    4'h0:    alu_res = rd_val & rs_val;
                    4'h1:    alu_res = rd_val | rs_val;
                    default: alu_res = rd_val ^ rs_val;
                endcase
            end
            OP_ARITH: begin
                alu_we  = 1'b1;
                alu_res = sub[0] ? (rd_val - rs_val) : (rd_val + rs_val);
            end
            OP_CI8: begin
                alu_we  = 1'b1;
                alu_res = imm_w;
            end
            OP_BRZ: begin
                br_take   = (rd_val == '0);
                br_target = pc + imm_a;
            end
            default: ;
        endcase
    end

    // Next state and request outputs; requests depend on the state register only.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_illegal || is_trap) state_d = S_HALT;
                else if (is_mem)            state_d = S_MEM;
                else                        state_d = S_EXEC;
            end
            S_EXEC: state_d = S_FETCH;
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_d = is_store ? S_FETCH : S_WB;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register here samples the values from before the clock edge.
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            mdr     <= '0;
            instret <= '0;
            halt    <= 1'b0;
            illegal <= 1'b0;
            // NOTE: the register file is architectural state that must read
            // zero after reset, so it lives in flops and is cleared here.
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        halt    <= 1'b1;
                        illegal <= 1'b1;
                    end else if (is_trap) begin
                        halt <= 1'b1;
                    end
                end
                S_EXEC: begin
                    instret <= instret + 32'd1;
                    if (alu_we)  regs[rd_idx] <= alu_res;
                    if (br_take) pc <= br_target;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_store) instret <= instret + 32'd1;
                        else          mdr <= dmem_rdata;
                    end
                end
                S_WB: begin
                    regs[rd_idx] <= mdr;
                    instret      <= instret + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Data-port payload is driven only while a data access is in progress.
    logic in_mem;
    assign in_mem     = (state_q == S_MEM);
    assign imem_addr  = pc;
    assign dmem_we    = in_mem && is_store;
    assign dmem_addr  = in_mem ? ADDR_W'(rs_val) : '0;
    assign dmem_wdata = in_mem ? rd_val : '0;

endmodule

// File: tb/tb_multicycle_core.sv
module tb_multicycle_core;

    localparam int WIDTH  = 16;
    localparam int REGS   = 8;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              halt, illegal;
    logic [31:0]       instret;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata = '0;
    logic              imem_ack = 1'b0;
    logic              dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [WIDTH-1:0]  dmem_wdata;
    logic [WIDTH-1:0]  dmem_rdata = '0;
    logic              dmem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0]       imem [65536];
    logic [WIDTH-1:0]  dmem [65536];
    bit                imem_auto = 1'b1;
    int                imem_wait = 0;
    int                dmem_wait = 0;
    logic [WIDTH-1:0]  st_data [$];
    logic [ADDR_W-1:0] st_addr [$];

    multicycle_core #(.WIDTH(WIDTH), .REGS(REGS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .illegal    (illegal),
        .instret    (instret),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    always #5 clk = ~clk;

    // Instruction memory: acks after imem_wait extra request cycles.
    initial begin : imem_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) cnt = 0;
            if (imem_auto) begin
                if (imem_req !== 1'b1) begin
                    imem_ack = 1'b0;
                    cnt = 0;
                end else if (cnt >= imem_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem[imem_addr];
                    cnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Data memory: acks after dmem_wait extra request cycles, logs stores.
    initial begin : dmem_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) cnt = 0;
            if (dmem_req !== 1'b1) begin
                dmem_ack = 1'b0;
                cnt = 0;
            end else if (cnt >= dmem_wait) begin
                dmem_ack = 1'b1;
                if (dmem_we === 1'b1) begin
                    dmem[dmem_addr] = dmem_wdata;
                    st_data.push_back(dmem_wdata);
                    st_addr.push_back(dmem_addr);
                end
                dmem_rdata = dmem[dmem_addr];
                cnt = 0;
            end else begin
                dmem_ack = 1'b0;
                cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the falling edge right after the reset edge.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        st_data.delete();
        st_addr.delete();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            imem[i] = 16'h0000;
            dmem[i] = '0;
        end
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        cycles = 0;
        while (halt !== 1'b1 && cycles < budget) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic test_reset();
        clear_mem();
        apply_reset();
        checks++;
        if ({imem_req, dmem_req, dmem_we, halt, illegal} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 10000", {imem_req, dmem_req, dmem_we, halt, illegal});
        end
        checks++;
        if (imem_addr !== 16'h0000 || dmem_addr !== 16'h0000 || dmem_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bus: imem_addr %h dmem_addr %h wdata %h expected all 0", imem_addr, dmem_addr, dmem_wdata);
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_instret: got %0d expected 0", instret);
        end
    endtask

    task automatic test_basic();
        int cyc;
        clear_mem();
        imem[0] = 16'hB051;  // ci8 r1,5
        imem[1] = 16'hBFD2;  // ci8 r2,-3
        imem[2] = 16'h7021;  // add r1,r2
        imem[3] = 16'h4101;  // st  r1,[r0]
        imem[4] = 16'h0000;  // trap
        apply_reset();
        step(8);
        checks++;
        if (instret !== 32'd2) begin
            errors++;
            $display("FAIL basic_instret_c8: got %0d expected 2", instret);
        end
        step(1);
        checks++;
        if (instret !== 32'd3 || halt !== 1'b0) begin
            errors++;
            $display("FAIL basic_instret_c9: instret %0d halt %b expected 3 0", instret, halt);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0003) begin
            errors++;
            $display("FAIL basic_next_fetch: req %b addr %h expected 1 0003", imem_req, imem_addr);
        end
        run_to_halt(30, cyc);
        checks++;
        if (halt !== 1'b1) begin
            errors++;
            $display("FAIL basic_timeout: halt %b after %0d cycles", halt, cyc);
        end
        checks++;
        if (st_data.size() != 1 || st_data[0] !== 16'h0002 || st_addr[0] !== 16'h0000) begin
            errors++;
            $display("FAIL basic_r1: stores %0d data %h expected 1 store of 0002 at 0000", st_data.size(), st_data.size() > 0 ? st_data[0] : 16'hxxxx);
        end
    endtask

    task automatic test_alu();
        int cyc;
        logic [15:0] exp_st [7];
        exp_st = '{16'hFFA5, 16'hFFA6, 16'h0052, 16'hFFF3, 16'h0000, 16'h000D, 16'h0000};
        clear_mem();
        imem[0]  = 16'hB5A1;  // ci8 r1,0x5A
        imem[1]  = 16'hBF32;  // ci8 r2,0xF3 -> FFF3
        imem[2]  = 16'hB407;  // ci8 r7,0x40
        imem[3]  = 16'h1013;  // not r3,r1
        imem[4]  = 16'h4173;  // st  r3,[r7]
        imem[5]  = 16'h3014;  // neg r4,r1
        imem[6]  = 16'h4174;  // st  r4,[r7]
        imem[7]  = 16'h5021;  // and r1,r2
        imem[8]  = 16'h4171;
        imem[9]  = 16'h5121;  // or  r1,r2
        imem[10] = 16'h4171;
        imem[11] = 16'h5221;  // xor r1,r2
        imem[12] = 16'h4171;
        imem[13] = 16'h7121;  // sub r1,r2
        imem[14] = 16'h4171;
        imem[15] = 16'h7021;  // add r1,r2 (wraps to 0)
        imem[16] = 16'h4171;
        imem[17] = 16'h0000;
        apply_reset();
        run_to_halt(200, cyc);
        checks++;
        if (halt !== 1'b1 || illegal !== 1'b0 || instret !== 32'd17) begin
            errors++;
            $display("FAIL alu_end: halt %b illegal %b instret %0d expected 1 0 17", halt, illegal, instret);
        end
        checks++;
        if (st_data.size() != 7) begin
            errors++;
            $display("FAIL alu_store_count: got %0d expected 7", st_data.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (st_data[i] !== exp_st[i] || st_addr[i] !== 16'h0040) begin
                    errors++;
                    $display("FAIL alu_result_%0d: got %h at %h expected %h at 0040", i, st_data[i], st_addr[i], exp_st[i]);
                end
            end
        end
    endtask

    task automatic test_load();
        int cyc, req_cyc, bad;
        clear_mem();
        imem[0] = 16'hB205;  // ci8 r5,0x20
        imem[1] = 16'h4056;  // ld  r6,[r5]
        imem[2] = 16'h4106;  // st  r6,[r0]
        imem[3] = 16'h0000;
        dmem[16'h0020] = 16'hBEEF;
        dmem_wait = 4;
        apply_reset();
        step(3);
        cyc = 0;
        req_cyc = 0;
        bad = 0;
        while (instret !== 32'd2 && cyc < 30) begin
            step(1);
            cyc++;
            if (dmem_req === 1'b1) begin
                req_cyc++;
                if (dmem_addr !== 16'h0020 || dmem_we !== 1'b0) bad++;
            end
        end
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL load_latency: got %0d cycles expected 8", cyc);
        end
        checks++;
        if (req_cyc != 5 || bad != 0) begin
            errors++;
            $display("FAIL load_req: high %0d cycles, %0d unstable, expected 5 and 0", req_cyc, bad);
        end
        dmem_wait = 0;
        run_to_halt(30, cyc);
        checks++;
        if (st_data.size() != 1 || st_data[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL load_data: stores %0d data %h expected BEEF", st_data.size(), st_data.size() > 0 ? st_data[0] : 16'hxxxx);
        end
    endtask

    task automatic test_wait_states();
        clear_mem();
        imem[0] = 16'hB051;  // ci8 r1,5
        imem[1] = 16'h4101;  // st r1,[r0]
        imem[2] = 16'h0000;
        imem_wait = 2;
        dmem_wait = 1;
        apply_reset();
        step(10);
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL wait_c10: instret %0d expected 1", instret);
        end
        step(1);
        checks++;
        if (instret !== 32'd2 || st_data.size() != 1 || st_data[0] !== 16'h0005) begin
            errors++;
            $display("FAIL wait_c11: instret %0d stores %0d expected 2 and one store of 0005", instret, st_data.size());
        end
        imem_wait = 0;
        dmem_wait = 0;
    endtask

    task automatic test_brz();
        int steps;
        logic [15:0] exp_addr;
        for (int i = 0; i < 2; i++) begin
            clear_mem();
            if (i == 0) begin
                imem[0] = 16'hB104;  // ci8 r4,0x10
                imem[1] = 16'h0104;  // jr r4
                steps = 9;
                exp_addr = 16'h000F;
            end else begin
                imem[0] = 16'hB013;  // ci8 r3,1
                imem[1] = 16'hB104;
                imem[2] = 16'h0104;
                steps = 12;
                exp_addr = 16'h0011;
            end
            imem[16'h0010] = 16'hEFE3;  // brz r3,-2
            apply_reset();
            step(steps - 3);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
                errors++;
                $display("FAIL brz_jr_%0d: req %b addr %h expected 1 0010", i, imem_req, imem_addr);
            end
            step(3);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                errors++;
                $display("FAIL brz_target_%0d: req %b addr %h expected 1 %h", i, imem_req, imem_addr, exp_addr);
            end
        end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        imem[0]        = 16'hBFF1;  // ci8 r1,-1
        imem[1]        = 16'h0101;  // jr r1
        imem[16'hFFFF] = 16'h1012;  // not r2,r1
        apply_reset();
        step(6);
        checks++;
        if (imem_addr !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_jr: addr %h expected FFFF", imem_addr);
        end
        step(3);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instret !== 32'd3) begin
            errors++;
            $display("FAIL wrap_pc: req %b addr %h instret %0d expected 1 0000 3", imem_req, imem_addr, instret);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] enc [4];
        int req_cyc;
        enc = '{16'h9000, 16'hB009, 16'h1092, 16'h5321};
        for (int i = 0; i < 4; i++) begin
            clear_mem();
            imem[0] = enc[i];
            apply_reset();
            step(2);
            checks++;
            if (halt !== 1'b1 || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%h: halt %b illegal %b expected 1 1", enc[i], halt, illegal);
            end
            req_cyc = 0;
            for (int c = 0; c < 4; c++) begin
                if (imem_req !== 1'b0 || dmem_req !== 1'b0) req_cyc++;
                step(1);
            end
            checks++;
            if (req_cyc != 0 || instret !== 32'd0 || halt !== 1'b1) begin
                errors++;
                $display("FAIL illegal_sticky_%h: req cycles %0d instret %0d halt %b expected 0 0 1", enc[i], req_cyc, instret, halt);
            end
        end
    endtask

    task automatic test_trap();
        clear_mem();
        imem[0] = 16'h0000;
        apply_reset();
        step(1);
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL trap_c1: halt %b expected 0", halt);
        end
        step(1);
        checks++;
        if (halt !== 1'b1 || illegal !== 1'b0 || imem_req !== 1'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL trap_c2: halt %b illegal %b req %b instret %0d expected 1 0 0 0", halt, illegal, imem_req, instret);
        end
    endtask

    task automatic test_reset_pending();
        int cyc;
        clear_mem();
        imem[0] = 16'hB051;  // ci8 r1,5
        imem_auto = 1'b1;
        apply_reset();
        step(2);
        imem_auto = 1'b0;
        imem_ack = 1'b0;
        step(3);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0001 || instret !== 32'd1) begin
            errors++;
            $display("FAIL pend_wait: req %b addr %h instret %0d expected 1 0001 1", imem_req, imem_addr, instret);
        end
        reset = 1'b1;
        step(1);
        imem_ack = 1'b1;
        imem_rdata = 16'h9000;
        step(1);
        reset = 1'b0;
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instret !== 32'd0 || halt !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL pend_restart: req %b addr %h instret %0d halt %b illegal %b expected 1 0000 0 0 0", imem_req, imem_addr, instret, halt, illegal);
        end
        imem[0] = 16'h4101;  // st r1,[r0]
        imem[1] = 16'h0000;
        dmem[0] = 16'hAAAA;
        st_data.delete();
        st_addr.delete();
        imem_auto = 1'b1;
        run_to_halt(30, cyc);
        checks++;
        if (halt !== 1'b1 || illegal !== 1'b0 || st_data.size() != 1 || st_data[0] !== 16'h0000 || instret !== 32'd1) begin
            errors++;
            $display("FAIL pend_regs_cleared: halt %b illegal %b stores %0d instret %0d expected 1 0 1 store of 0000 and 1", halt, illegal, st_data.size(), instret);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alu();
        test_load();
        test_wait_states();
        test_brz();
        test_pc_wrap();
        test_illegal();
        test_trap();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle processor core: next generation of the Start/Decode state-machine processor, with configurable datapath width, register count and address width. It executes a decided 16-bit instruction subset through a fetch/decode/execute/memory/writeback FSM. Instructions come through a separate instruction port and data through a separate data port, both using req/ack handshakes that tolerate any memory latency. Halt is sticky, illegal encodings are flagged, and a retired-instruction counter is provided.

## Interface
- WIDTH, 16: datapath/register width; must be >= 16.
- REGS, 8: number of registers, 2..16.
- ADDR_W, 16: width of pc and both memory addresses.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- halt  out  1  sticky; set on trap or illegal instruction.
- illegal  out  1  sticky; set with halt when the halt cause is illegal.
- instret  out  32  count of retired instructions (trap/illegal not counted).
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_rdata  in  16  instruction word.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- dmem_req  out  1  data request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  ADDR_W  low ADDR_W bits of r[rs], zero-extended if WIDTH < ADDR_W.
- dmem_wdata  out  WIDTH  store data (r[rd]).
- dmem_rdata  in  WIDTH  load data.
- dmem_ack  in  1  data access complete.

## Operation
- Instruction fields: op=[15:12], sub=[11:8], rs=[7:4], rd=[3:0], imm8=[11:4] (sign-extended to WIDTH/ADDR_W).
- op 0x0: sub 0 = trap (halt); sub 1 = jr (pc<=r[rd]).
- op 0x1: not (rd<=~rs).
- op 0x3: neg (rd<=-rs, two's complement).
- op 0x4: sub 0 = load (rd<=mem[r[rs]]); sub 1 = store (mem[r[rs]]<=r[rd]).
- op 0x5: sub 0/1/2 = and/or/xor (rd<=rd op rs).
- op 0x7: sub 0/1 = add/sub (rd<=rd±rs, modulo 2^WIDTH, no flags).
- op 0xB: ci8 (rd<=sext(imm8)).
- op 0xE: brz (if r[rd]==0 then pc<=pc+sext(imm8), using the already-incremented pc).
- Illegal: any other op or sub, or rs/rd >= REGS when that field is used. Response: halt<=1, illegal<=1, no register or pc side effects.
- FSM states:
  - FETCH: imem_req=1; on imem_ack, ir<=imem_rdata and pc<=pc+1 (wraps 2^ADDR_W-1 -> 0); go to DECODE.
  - DECODE: trap/illegal -> HALT; load/store -> MEM; otherwise -> EXEC.
  - EXEC: write rd or update pc; go to FETCH.
  - MEM: dmem_req=1; on dmem_ack, load -> WB, store -> FETCH.
  - WB: rd<=captured rdata; go to FETCH.
  - HALT: absorbing; leave only via reset.
- imem_req and dmem_req are decoded from the state register only (no input-to-output path).
- instret increments at the end of EXEC, WB, or store MEM; wraps at 2^32.
- Branch/jr targets wrap modulo 2^ADDR_W.

## Timing
- On a reset cycle: pc, registers, instret, halt, illegal = 0; state <= FETCH; all outputs low/zero on the following cycle except imem_req=1 (FETCH).
- Handshake: req rises and holds address/data stable until an edge where ack=1. That edge completes the access; req is low (or shows the next access) on the next cycle. ack while req is low is ignored.
- Zero-wait memory (ack in the first req cycle): ALU/ci8/brz/jr = 3 cycles; store = 3; load = 4; trap reaches HALT in 2. Each wait cycle adds 1.
- Reset during a pending access: the request is dropped next cycle; a late ack is ignored.
- reset and ack in the same cycle: reset wins; no state update.

## Test plan
- Reset, then ci8 r1,5; ci8 r2,-3; add r1,r2 with zero-wait memory -> r1=2, instret=3 after 9 cycles, halt=0.
- Load with dmem_ack delayed 4 cycles, mem[0x20]=0xBEEF -> dmem_req high for exactly 5 cycles, address stable, rd=0xBEEF, load takes 8 cycles.
- brz r3 with r3=0 and imm8=0xFE at pc=0x10 -> next fetch at 0x0F; with r3=1 -> next fetch at 0x11.
- pc=0xFFFF executes not -> next imem_addr=0x0000 (wrap).
- Instruction 0x9000 or rd=9 with REGS=8 -> halt=1, illegal=1, no further imem_req; trap 0x0000 -> halt=1, illegal=0.
- Assert reset while imem_req is waiting, ack arrives one cycle later -> ack ignored, fetch restarts at pc=0, registers cleared.
